// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the IF PC, issues fetches to a 1-cycle synchronous inst SRAM
// and holds the returned word while ID stalls, so nothing is lost or refetched.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allow_in,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] PC_RESET = RESET_PC - 32'd4;

  logic        pre_valid_r;
  logic        fs_valid_r;
  logic [31:0] fs_pc_r;
  logic [31:0] inst_buf_r;
  logic        inst_buf_valid_r;
  logic        rdata_fresh_r;

  logic [31:0] seq_pc_s;
  logic [31:0] next_pc_s;
  logic        fs_ready_go_s;
  logic        fs_allow_in_s;
  logic        fetch_s;
  logic        hold_s;

  // Next-PC selection and IF handshake terms.
  always_comb begin
    seq_pc_s      = fs_pc_r + PC_STEP;
    next_pc_s     = seq_pc_s;
    fs_ready_go_s = 1'b1;
    if (br_taken_cancel) begin
      next_pc_s = br_target;
    end else begin
      next_pc_s = seq_pc_s;
    end
    fs_allow_in_s = ~fs_valid_r | (fs_ready_go_s & ds_allow_in) | br_taken_cancel;
    fetch_s       = pre_valid_r & fs_allow_in_s;
    // Capture only a word that is still on the SRAM bus and not being squashed.
    hold_s        = fs_valid_r & rdata_fresh_r & ~ds_allow_in & ~br_taken_cancel;
  end

  // Output drive.
  always_comb begin
    inst_sram_en   = fetch_s;
    inst_sram_we   = 4'b0000;
    inst_sram_addr = next_pc_s;
    fs_to_ds_valid = fs_valid_r & fs_ready_go_s & ~br_taken_cancel;
    fs_pc          = fs_pc_r;
    if (inst_buf_valid_r) begin
      fs_inst = inst_buf_r;
    end else begin
      fs_inst = inst_sram_rdata;
    end
  end

  // Fetch-enable gate: opens on the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_valid_r <= 1'b0;
    end else begin
      pre_valid_r <= 1'b1;
    end
  end

  // IF valid flag and PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid_r <= 1'b0;
      fs_pc_r    <= PC_RESET;
    end else if (fetch_s) begin
      fs_valid_r <= 1'b1;
      fs_pc_r    <= next_pc_s;
    end else if (br_taken_cancel) begin
      fs_valid_r <= 1'b0;
      fs_pc_r    <= fs_pc_r;
    end else begin
      fs_valid_r <= fs_valid_r;
      fs_pc_r    <= fs_pc_r;
    end
  end

  // Tracks whether the SRAM output currently belongs to fs_pc.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_fresh_r <= 1'b0;
    end else begin
      rdata_fresh_r <= fetch_s;
    end
  end

  // Stall hold buffer; any new fetch means the held word left IF or was squashed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf_r       <= 32'h0000_0000;
      inst_buf_valid_r <= 1'b0;
    end else if (fetch_s) begin
      inst_buf_r       <= inst_buf_r;
      inst_buf_valid_r <= 1'b0;
    end else if (hold_s) begin
      inst_buf_r       <= inst_sram_rdata;
      inst_buf_valid_r <= 1'b1;
    end else begin
      inst_buf_r       <= inst_buf_r;
      inst_buf_valid_r <= inst_buf_valid_r;
    end
  end

endmodule
